// File: rtl/fetch_unit.sv
// Fetch unit: owns the PC, runs a req/ack handshake to IMEM and hands instructions to decode.
// Define FETCH_PERF_CNT_EN to add the StallCnt/FetchCnt performance counters.
module fetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h0000_0013)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [5:0]        CtrlWrd,
    input  logic [ADDR_W-1:0] BranchTgt,
    output logic              ImemReq,
    output logic [ADDR_W-1:0] ImemAddr,
    input  logic              ImemAck,
    input  logic [DATA_W-1:0] ImemData,
    output logic [DATA_W-1:0] Instr,
    output logic [ADDR_W-1:0] InstrPc,
    output logic              InstrValid,
    input  logic              DecReady,
    output logic [ADDR_W-1:0] Pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       StallCnt,
    output logic [31:0]       FetchCnt
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, VALID} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              valid_q, valid_d;
    logic [5:0]        cw_q, cw_d;
    logic              drop_q, drop_d;

    logic              flush, imem_re;
    logic [ADDR_W-1:0] tgt_aligned;
    logic              unused_bits;

    assign flush       = CtrlWrd[2];
    assign imem_re     = CtrlWrd[3];
    assign tgt_aligned = {BranchTgt[ADDR_W-1:2], 2'b00};
    assign unused_bits = ^{CtrlWrd[0], cw_q[3:2], cw_q[0], BranchTgt[1:0]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            instr_q <= NOP_INSTR;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            cw_q    <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            cw_q    <= cw_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!flush && imem_re) state_d = REQ;
            REQ:     if (ImemAck) state_d = (!flush && !drop_q && cw_q[1]) ? VALID : IDLE;
            VALID: begin
                if (flush)         state_d = IDLE;
                else if (DecReady) state_d = imem_re ? REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        cw_d    = cw_q;
        drop_d  = drop_q;
        unique case (state_q)
            IDLE: begin
                if (!flush && imem_re) begin
                    cw_d   = CtrlWrd;
                    req_d  = 1'b1;
                    addr_d = pc_q;
                end
            end
            REQ: begin
                if (ImemAck) begin
                    req_d  = 1'b0;
                    drop_d = 1'b0;
                    // A flushed or already-dropped request completes without side effects.
                    if (!flush && !drop_q) begin
                        if (cw_q[5]) pc_d = cw_q[4] ? tgt_aligned : pc_q + ADDR_W'(4);
                        if (cw_q[1]) begin
                            instr_d = ImemData;
                            ipc_d   = addr_q;
                            valid_d = 1'b1;
                        end
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            VALID: begin
                if (!flush && DecReady) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    if (imem_re) begin
                        cw_d   = CtrlWrd;
                        req_d  = 1'b1;
                        addr_d = pc_q;
                    end
                end
            end
            default: ;
        endcase
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            if (CtrlWrd[4]) pc_d = tgt_aligned;
        end
    end

    assign Pc         = pc_q;
    assign ImemReq    = req_q;
    assign ImemAddr   = addr_q;
    assign Instr      = instr_q;
    assign InstrPc    = ipc_q;
    assign InstrValid = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, fetch_cnt_q;
    logic        stall_evt, fetch_evt;

    assign stall_evt = ((state_q == REQ) && !ImemAck) || ((state_q == VALID) && !DecReady);
    assign fetch_evt = valid_q && DecReady;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stall_cnt_q <= '0;
            fetch_cnt_q <= '0;
        end else begin
            if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (fetch_evt && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FetchCnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: a vector table for the basic fetch flow plus
// hand-written sequences for stall, flush, async reset and (optionally) the perf counters.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [5:0]  CtrlWrd;
    logic [31:0] BranchTgt;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;
    logic [31:0] Instr;
    logic [31:0] InstrPc;
    logic        InstrValid;
    logic        DecReady;
    logic [31:0] Pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] StallCnt;
    logic [31:0] FetchCnt;
`endif

    fetch_unit dut (
        .Clk(Clk), .Rst(Rst), .CtrlWrd(CtrlWrd), .BranchTgt(BranchTgt),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemData(ImemData),
        .Instr(Instr), .InstrPc(InstrPc), .InstrValid(InstrValid), .DecReady(DecReady),
        .Pc(Pc)
`ifdef FETCH_PERF_CNT_EN
        , .StallCnt(StallCnt), .FetchCnt(FetchCnt)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [5:0]  ctrl;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] data;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] c, input logic [31:0] t, input logic a,
                         input logic [31:0] d, input logic r);
        CtrlWrd   = c;
        BranchTgt = t;
        ImemAck   = a;
        ImemData  = d;
        DecReady  = r;
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] instr,
                             input logic [31:0] ipc, input logic [31:0] pc);
        check({tag, ".req"},   {31'd0, ImemReq},    {31'd0, req});
        check({tag, ".addr"},  ImemAddr,            addr);
        check({tag, ".valid"}, {31'd0, InstrValid}, {31'd0, valid});
        check({tag, ".instr"}, Instr,               instr);
        check({tag, ".ipc"},   InstrPc,             ipc);
        check({tag, ".pc"},    Pc,                  pc);
    endtask

    initial begin
        // ctrl, tgt, ack, data | req, addr, valid, instr, ipc, pc  (DecReady=1 throughout)
        vecs.push_back('{6'h2A, 32'h0,   1'b0, 32'h0,         1'b1, 32'h0,   1'b0, NOP,           32'h0,  32'h0});
        vecs.push_back('{6'h00, 32'h0,   1'b0, 32'h0,         1'b1, 32'h0,   1'b0, NOP,           32'h0,  32'h0});
        vecs.push_back('{6'h00, 32'h0,   1'b1, 32'h00500093,  1'b0, 32'h0,   1'b1, 32'h00500093,  32'h0,  32'h4});
        vecs.push_back('{6'h00, 32'h0,   1'b0, 32'h0,         1'b0, 32'h0,   1'b0, NOP,           32'h0,  32'h4});
        vecs.push_back('{6'h2A, 32'h0,   1'b0, 32'h0,         1'b1, 32'h4,   1'b0, NOP,           32'h0,  32'h4});
        vecs.push_back('{6'h00, 32'h0,   1'b1, 32'hA1,        1'b0, 32'h4,   1'b1, 32'hA1,        32'h4,  32'h8});
        vecs.push_back('{6'h00, 32'h0,   1'b0, 32'h0,         1'b0, 32'h4,   1'b0, NOP,           32'h4,  32'h8});
        vecs.push_back('{6'h2A, 32'h0,   1'b0, 32'h0,         1'b1, 32'h8,   1'b0, NOP,           32'h4,  32'h8});
        vecs.push_back('{6'h00, 32'h0,   1'b1, 32'hA2,        1'b0, 32'h8,   1'b1, 32'hA2,        32'h8,  32'hC});
        vecs.push_back('{6'h00, 32'h0,   1'b0, 32'h0,         1'b0, 32'h8,   1'b0, NOP,           32'h8,  32'hC});
        vecs.push_back('{6'h2A, 32'h0,   1'b0, 32'h0,         1'b1, 32'hC,   1'b0, NOP,           32'h8,  32'hC});
        vecs.push_back('{6'h00, 32'h0,   1'b1, 32'hA3,        1'b0, 32'hC,   1'b1, 32'hA3,        32'hC,  32'h10});
        vecs.push_back('{6'h00, 32'h0,   1'b0, 32'h0,         1'b0, 32'hC,   1'b0, NOP,           32'hC,  32'h10});
        // branch redirect with unaligned target
        vecs.push_back('{6'h3A, 32'h103, 1'b0, 32'h0,         1'b1, 32'h10,  1'b0, NOP,           32'hC,  32'h10});
        vecs.push_back('{6'h00, 32'h103, 1'b1, 32'hA4,        1'b0, 32'h10,  1'b1, 32'hA4,        32'h10, 32'h100});
        vecs.push_back('{6'h00, 32'h0,   1'b0, 32'h0,         1'b0, 32'h10,  1'b0, NOP,           32'h10, 32'h100});
        // IrEn=0: PC advances, data discarded
        vecs.push_back('{6'h28, 32'h0,   1'b0, 32'h0,         1'b1, 32'h100, 1'b0, NOP,           32'h10, 32'h100});
        vecs.push_back('{6'h00, 32'h0,   1'b1, BAD,           1'b0, 32'h100, 1'b0, NOP,           32'h10, 32'h104});
        // stray ack in IDLE is ignored
        vecs.push_back('{6'h00, 32'h0,   1'b1, BAD,           1'b0, 32'h100, 1'b0, NOP,           32'h10, 32'h104});

        Rst = 1'b1; CtrlWrd = '0; BranchTgt = '0; ImemAck = 1'b0; ImemData = '0; DecReady = 1'b1;
        #12;
        check_all("reset", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0);
        @(posedge Clk); #1;
        Rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].ctrl, vecs[i].tgt, vecs[i].ack, vecs[i].data, 1'b1);
            check_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                      vecs[i].instr, vecs[i].ipc, vecs[i].pc);
        end

        // Decode stall: held output, no new request, then back-to-back accept+issue
        drive(6'h2A, 32'h0, 1'b0, 32'h0, 1'b0);
        drive(6'h00, 32'h0, 1'b1, 32'hB1, 1'b0);
        check_all("stall.cap", 1'b0, 32'h104, 1'b1, 32'hB1, 32'h104, 32'h108);
        for (int k = 0; k < 5; k++) begin
            drive(6'h2A, 32'h0, 1'b0, 32'h0, 1'b0);
            check_all($sformatf("stall.hold%0d", k), 1'b0, 32'h104, 1'b1, 32'hB1, 32'h104, 32'h108);
        end
        drive(6'h2A, 32'h0, 1'b0, 32'h0, 1'b1);
        check_all("stall.b2b", 1'b1, 32'h108, 1'b0, NOP, 32'h104, 32'h108);
        drive(6'h00, 32'h0, 1'b1, 32'hB2, 1'b1);
        check_all("stall.ack", 1'b0, 32'h108, 1'b1, 32'hB2, 32'h108, 32'h10C);
        drive(6'h00, 32'h0, 1'b0, 32'h0, 1'b1);

        // Flush while a request is outstanding
        drive(6'h2A, 32'h0, 1'b0, 32'h0, 1'b1);
        check_all("flush.issue", 1'b1, 32'h10C, 1'b0, NOP, 32'h108, 32'h10C);
        drive(6'h14, 32'h200, 1'b0, 32'h0, 1'b1);
        check_all("flush.req", 1'b1, 32'h10C, 1'b0, NOP, 32'h108, 32'h200);
        drive(6'h00, 32'h0, 1'b1, BAD, 1'b1);
        check_all("flush.drop", 1'b0, 32'h10C, 1'b0, NOP, 32'h108, 32'h200);
        drive(6'h2A, 32'h0, 1'b0, 32'h0, 1'b1);
        check_all("flush.next", 1'b1, 32'h200, 1'b0, NOP, 32'h108, 32'h200);
        drive(6'h00, 32'h0, 1'b1, 32'hC1, 1'b1);
        check_all("flush.nack", 1'b0, 32'h200, 1'b1, 32'hC1, 32'h200, 32'h204);
        drive(6'h00, 32'h0, 1'b0, 32'h0, 1'b1);

        // Async reset in the middle of a request, then a stray ack
        drive(6'h2A, 32'h0, 1'b0, 32'h0, 1'b1);
        check_all("rst.issue", 1'b1, 32'h204, 1'b0, NOP, 32'h200, 32'h204);
        CtrlWrd = 6'h00;
        #3 Rst = 1'b1;
        #1;
        check_all("rst.async", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        drive(6'h00, 32'h0, 1'b1, BAD, 1'b1);
        check_all("rst.stray", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0);

        // Three-cycle ack wait
        drive(6'h2A, 32'h0, 1'b0, 32'h0, 1'b1);
        drive(6'h00, 32'h0, 1'b0, 32'h0, 1'b1);
        drive(6'h00, 32'h0, 1'b0, 32'h0, 1'b1);
        check_all("wait3.req", 1'b1, 32'h0, 1'b0, NOP, 32'h0, 32'h0);
        drive(6'h00, 32'h0, 1'b1, 32'hD1, 1'b1);
        check_all("wait3.ack", 1'b0, 32'h0, 1'b1, 32'hD1, 32'h0, 32'h4);
`ifdef FETCH_PERF_CNT_EN
        check("perf.stall", StallCnt, 32'd2);
`endif
        drive(6'h00, 32'h0, 1'b0, 32'h0, 1'b1);
        check_all("wait3.acc", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h4);
`ifdef FETCH_PERF_CNT_EN
        check("perf.fetch", FetchCnt, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Consumer of the 6-bit fetch control word driven by the fetch controller.
- Latches the control word per transaction, owns the PC register, and runs a req/ack handshake to instruction memory.
- Presents the fetched instruction to decode over a valid/ready interface.
- Sits between the fetch controller/IMEM port and the decode stage.

Parameters:
ADDR_W, 32, PC / IMEM address width
DATA_W, 32, instruction width
RESET_PC, 32'h00000000, PC value after reset
NOP_INSTR, 32'h00000013, value of Instr when no valid instruction is held

Ports:
Clk  in  1  clock; all state updates on rising edge
Rst  in  1  asynchronous, active-high reset
CtrlWrd  in  6  control word; bit5 PcEn, bit4 PcSel, bit3 ImemRe, bit2 Flush, bit1 IrEn, bit0 reserved (ignored)
BranchTgt  in  ADDR_W  redirect target; low 2 bits forced to 0 on use
ImemReq  out  1  IMEM request
ImemAddr  out  ADDR_W  IMEM address; stable while ImemReq=1
ImemAck  in  1  IMEM response strobe, one cycle
ImemData  in  DATA_W  IMEM read data, valid when ImemAck=1
Instr  out  DATA_W  instruction to decode
InstrPc  out  ADDR_W  PC of Instr
InstrValid  out  1  Instr/InstrPc valid
DecReady  in  1  decode accepts when InstrValid & DecReady
Pc  out  ADDR_W  current PC register

Behaviour:
- Reset (async, active-high): state IDLE, Pc=RESET_PC, ImemReq=0, ImemAddr=RESET_PC, Instr=NOP_INSTR, InstrPc=0, InstrValid=0, CwReg=0, Drop=0.
- States: IDLE, REQ, VALID.
- IDLE:
  - If CtrlWrd[3]=1 (and Flush=0), go to REQ next cycle.
  - On that same edge: CwReg<=CtrlWrd, ImemReq<=1, ImemAddr<=Pc.
  - A zero control word keeps the block in IDLE.
- REQ:
  - ImemReq and ImemAddr are held until the ImemAck cycle.
  - On ack: ImemReq<=0. If CwReg[5]=1, Pc<=CwReg[4] ? {BranchTgt[ADDR_W-1:2],2'b00} : Pc+4 (wraps modulo 2^ADDR_W).
  - If CwReg[1]=1 and Drop=0: Instr<=ImemData, InstrPc<=ImemAddr, InstrValid<=1, go to VALID.
  - Otherwise go to IDLE; the data is discarded.
  - Latency: ImemReq rises 1 cycle after CtrlWrd[3] is sampled in IDLE; InstrValid rises 1 cycle after ImemAck.
- VALID:
  - Instr, InstrPc and InstrValid are held until DecReady=1.
  - On accept: InstrValid<=0, Instr<=NOP_INSTR.
  - If CtrlWrd[3]=1 in the accept cycle, go directly to REQ (back-to-back, same latch actions as IDLE); else go to IDLE.
  - No new request is issued while an instruction is unaccepted.
- Flush (CtrlWrd[2]=1, any state, highest priority):
  - InstrValid<=0, Instr<=NOP_INSTR.
  - If CtrlWrd[4]=1, Pc<=BranchTgt (aligned).
  - In REQ, the request cannot be aborted: ImemReq stays high until ack, Drop<=1, and the ack returns to IDLE with no Pc update from CwReg.
  - In IDLE/VALID, the next state is IDLE; a request is not started in a flush cycle.
- Drop clears on the ack cycle or on reset.
- Flush in the same cycle as ImemAck: the response is dropped, the flush Pc update wins, and the next state is IDLE.
- An ack outside REQ is ignored.
- Reset mid-transaction returns to reset values immediately; an in-flight IMEM response after reset is ignored (state IDLE).

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - adds output StallCnt (32 bit, reset 0), which increments each cycle with state REQ & ImemAck=0, or state VALID & DecReady=0;
  - adds output FetchCnt (32 bit, reset 0), which increments on each instruction accepted by decode;
  - both saturate at all-ones.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then CtrlWrd=6'b101010 with IMEM ack after 2 cycles, ImemData=32'h00500093, DecReady=1 -> ImemAddr=0, Instr=32'h00500093, InstrPc=0, InstrValid pulses once, Pc=4.
- Repeated 6'b101010 with 1-cycle ack -> fetch addresses 0,4,8,12; PC sequence correct; one instruction per 3 cycles.
- CtrlWrd=6'b111010, BranchTgt=32'h00000103 -> after ack, Pc=32'h00000100.
- DecReady held 0 for 5 cycles -> Instr/InstrPc stable and ImemReq stays 0; accept with CtrlWrd=6'b101010 -> ImemReq=1 next cycle.
- Flush 6'b010100, BranchTgt=32'h200, while in REQ before ack -> ImemReq stays high until ack; data dropped; InstrValid=0; Pc=32'h200; next fetch at 32'h200.
- Async Rst asserted mid-REQ -> outputs return to reset values without a clock edge; a later stray ImemAck is ignored. With FETCH_PERF_CNT_EN, 3-cycle ack wait -> StallCnt=2.
